// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master behind a 16-bit load/out register port; the CPU polls out[15] (busy).
// Build macro SPI_LOOPBACK_EN adds a loopback input that feeds the internal SDO back into the sampler.

module spi_master_param #(
  parameter int WIDTH = 8,
  parameter int DIV   = 2,
  parameter bit CPOL  = 1'b0,
  parameter bit CPHA  = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] in,
  input  logic        SDI,
`ifdef SPI_LOOPBACK_EN
  input  logic        loopback,
`endif
  output logic        CSX,
  output logic        SDO,
  output logic        SCK,
  output logic [15:0] out
);

  // state   | meaning
  // S_IDLE  | waiting for a command; CSX keeps its last level
  // S_SETUP | DIV cycles of CSX low with SCK at idle level before the first edge
  // S_SHIFT | 2*WIDTH SCK half-periods of DIV cycles each
  // S_HOLD  | DIV cycles after the last edge; received word already published

  localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BCW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

  state_t           r_state;
  logic [DCW-1:0]   r_div_cnt;
  logic [BCW-1:0]   r_bit_cnt;
  logic             r_phase;
  logic [WIDTH-1:0] r_tx;
  logic [WIDTH-1:0] r_rx;
  logic [WIDTH-1:0] r_word;
  logic             r_busy;
  logic             r_csx;
  logic             r_sck;
  logic             r_sdo;

  logic             w_div_last;
  logic             w_bit_last;
  logic             w_sample_edge;
  logic             w_sample_bit;
  logic [WIDTH-1:0] w_rx_next;
  logic             w_unused_in;

  assign w_div_last    = (r_div_cnt == DCW'(DIV - 1));
  assign w_bit_last    = (r_bit_cnt == BCW'(WIDTH - 1));
  // r_phase is 0 on the leading half of a bit, 1 on the trailing half
  assign w_sample_edge = (r_phase == CPHA);

`ifdef SPI_LOOPBACK_EN
  assign w_sample_bit = loopback ? r_sdo : SDI;
`else
  assign w_sample_bit = SDI;
`endif

  assign w_rx_next   = {r_rx[WIDTH-2:0], w_sample_bit};
  assign w_unused_in = ^in[15:WIDTH+1];

  assign CSX = r_csx;
  assign SDO = r_sdo;
  assign SCK = r_sck;
  assign out = {r_busy, {(15 - WIDTH){1'b0}}, r_word};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_phase   <= 1'b0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_word    <= '0;
      r_busy    <= 1'b0;
      r_csx     <= 1'b1;
      r_sck     <= CPOL;
      r_sdo     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load) begin
            if (in[WIDTH]) begin
              r_csx <= 1'b1;
            end else begin
              r_state   <= S_SETUP;
              r_busy    <= 1'b1;
              r_csx     <= 1'b0;
              r_tx      <= in[WIDTH-1:0];
              r_div_cnt <= '0;
              r_bit_cnt <= '0;
              r_phase   <= 1'b0;
              if (!CPHA) r_sdo <= in[WIDTH-1];
            end
          end
        end

        S_SETUP: begin
          r_sck <= CPOL;
          if (w_div_last) begin
            r_div_cnt <= '0;
            r_state   <= S_SHIFT;
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end

        S_SHIFT: begin
          if (!w_div_last) begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end else begin
            r_div_cnt <= '0;
            r_sck     <= ~r_sck;
            r_phase   <= ~r_phase;
            if (w_sample_edge) r_rx <= w_rx_next;
            // CPHA=0 already presented the MSB at load, so it shifts on trailing edges except the last
            if (!CPHA && r_phase && !w_bit_last) begin
              r_sdo <= r_tx[WIDTH-2];
              r_tx  <= {r_tx[WIDTH-2:0], 1'b0};
            end
            if (CPHA && !r_phase) begin
              r_sdo <= r_tx[WIDTH-1];
              r_tx  <= {r_tx[WIDTH-2:0], 1'b0};
            end
            if (r_phase) begin
              if (w_bit_last) begin
                r_state <= S_HOLD;
                r_word  <= w_sample_edge ? w_rx_next : r_rx;
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end
          end
        end

        S_HOLD: begin
          r_sck <= CPOL;
          if (w_div_last) begin
            r_div_cnt <= '0;
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: a mode-0/DIV=2 instance and a mode-3/DIV=1 instance, each checked every
// cycle against a timeline model derived from elapsed cycles since load, plus literal expectations.

module tb_spi_master_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic        ld    [2] = '{1'b0, 1'b0};
  logic [15:0] din   [2] = '{16'h0, 16'h0};
  logic        sdi_s [2] = '{1'b0, 1'b0};
  logic        lb = 1'b0;
  logic        chk_en = 1'b0;

  logic        csx0, sdo0, sck0, csx1, sdo1, sck1;
  logic [15:0] out0, out1;
  wire         sdi0_pin = lb ? 1'b0 : sdi_s[0];

  wire [18:0] obs [2];
  assign obs[0] = {csx0, sck0, sdo0, out0};
  assign obs[1] = {csx1, sck1, sdo1, out1};

  spi_master_param #(.WIDTH(8), .DIV(2), .CPOL(1'b0), .CPHA(1'b0)) u_mode0 (
    .clk(clk), .rst_n(rst_n), .load(ld[0]), .in(din[0]), .SDI(sdi0_pin),
`ifdef SPI_LOOPBACK_EN
    .loopback(lb),
`endif
    .CSX(csx0), .SDO(sdo0), .SCK(sck0), .out(out0));

  spi_master_param #(.WIDTH(8), .DIV(1), .CPOL(1'b1), .CPHA(1'b1)) u_mode3 (
    .clk(clk), .rst_n(rst_n), .load(ld[1]), .in(din[1]), .SDI(sdi_s[1]),
`ifdef SPI_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .CSX(csx1), .SDO(sdo1), .SCK(sck1), .out(out1));

  function automatic int div_of(int i);
    return (i == 0) ? 2 : 1;
  endfunction
  function automatic bit cpol_of(int i);
    return (i == 1);
  endfunction
  function automatic bit cpha_of(int i);
    return (i == 1);
  endfunction

  int n_chk = 0;
  int n_pass = 0;

  // Model bookkeeping: when each accepted transfer started and what it must produce
  int          cyc = 0;
  int          m_start [2];
  logic [7:0]  m_tx    [2];
  logic [7:0]  m_word  [2];
  logic [7:0]  m_prev  [2];
  logic        m_csx   [2];
  logic        m_hold  [2];
  logic [7:0]  s_resp  [2] = '{8'h00, 8'h00};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_start[i] <= -1;
        m_tx[i]    <= 8'h00;
        m_word[i]  <= 8'h00;
        m_prev[i]  <= 8'h00;
        m_csx[i]   <= 1'b1;
        m_hold[i]  <= 1'b0;
      end
    end else begin
      cyc <= cyc + 1;
      for (int i = 0; i < 2; i++) begin
        if (ld[i] && (m_start[i] < 0 || cyc - m_start[i] > 18 * div_of(i))) begin
          if (din[i][8]) begin
            m_csx[i] <= 1'b1;
          end else begin
            m_start[i] <= cyc;
            m_tx[i]    <= din[i][7:0];
            m_prev[i]  <= m_word[i];
            m_word[i]  <= (lb && i == 0) ? din[i][7:0] : s_resp[i];
            m_csx[i]   <= 1'b0;
            m_hold[i]  <= (m_start[i] >= 0) ? m_tx[i][0] : m_hold[i];
          end
        end
      end
    end
  end

  // Expected {CSX, SCK, SDO, out} from the elapsed cycle count j since the load edge
  function automatic logic [18:0] model_out(int i);
    int d, j, e, b;
    logic [7:0] t;
    logic sdo_e, busy_e;
    logic [7:0] word_e;
    d = div_of(i);
    t = m_tx[i];
    if (m_start[i] < 0) return {m_csx[i], cpol_of(i), m_hold[i], 1'b0, 7'b0, m_word[i]};
    j = cyc - 1 - m_start[i];
    e = (j < 2 * d) ? 0 : j / d - 1;
    if (e > 16) e = 16;
    busy_e = (j < 18 * d);
    word_e = (j < 17 * d) ? m_prev[i] : m_word[i];
    if (!cpha_of(i)) begin
      b = e / 2;
      if (b > 7) b = 7;
      sdo_e = t[7 - b];
    end else if (e == 0) begin
      sdo_e = m_hold[i];
    end else begin
      b = (e + 1) / 2 - 1;
      if (b > 7) b = 7;
      sdo_e = t[7 - b];
    end
    return {m_csx[i], cpol_of(i) ^ e[0], sdo_e, busy_e, 7'b0, word_e};
  endfunction

  logic [18:0] ex;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        ex = model_out(i);
        n_chk++;
        if (obs[i] === ex) n_pass++;
        else $display("FAIL model_u%0d t=%0t csx/sck/sdo/out got %b/%b/%b/%h want %b/%b/%b/%h",
                      i, $time, obs[i][18], obs[i][17], obs[i][16], obs[i][15:0],
                      ex[18], ex[17], ex[16], ex[15:0]);
      end
    end
  end

  // Slave: counts SCK edges within a transfer and presents its response MSB first
  int         sc  [2] = '{0, 0};
  logic       sl  [2] = '{1'b0, 1'b0};
  int         bc  [2] = '{0, 0};
  int         rc  [2] = '{0, 0};
  logic [7:0] cap [2] = '{8'h00, 8'h00};
  int         c_s, ix_s;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      c_s = !obs[i][15] ? 0 : ((obs[i][17] != sl[i]) ? sc[i] + 1 : sc[i]);
      ix_s = cpha_of(i) ? ((c_s + 1) / 2 - 1) : c_s / 2;
      if (ix_s < 0) ix_s = 0;
      if (ix_s > 7) ix_s = 7;
      sc[i]    <= c_s;
      sl[i]    <= obs[i][17];
      sdi_s[i] <= s_resp[i][7 - ix_s];
      if (obs[i][15]) bc[i] <= bc[i] + 1;
      if (obs[i][17] && !sl[i]) begin
        rc[i]  <= rc[i] + 1;
        cap[i] <= {cap[i][6:0], obs[i][16]};
      end
    end
  end

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s got %h want %h", name, got, want);
  endtask

  task automatic do_load(int i, logic [15:0] v);
    @(posedge clk); #2;
    ld[i] = 1'b1;
    din[i] = v;
    @(posedge clk); #2;
    ld[i] = 1'b0;
  endtask

  task automatic wait_idle(int i, int budget);
    int k;
    k = 0;
    while (obs[i][15] && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_chk++;
    if (!obs[i][15]) n_pass++;
    else $display("FAIL idle_timeout_u%0d busy got 1 want 0 after %0d cycles", i, budget);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  int b0, r0, k;

  initial begin
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    @(negedge clk); #1;
    chk("rst_csx0", csx0, 1);
    chk("rst_sck0", sck0, 0);
    chk("rst_sck1", sck1, 1);
    chk("rst_out0", out0, 16'h0000);
    chk("rst_sdo0", sdo0, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // mode 0, JEDEC id opcode, slave answers 0xEF
    s_resp[0] = 8'hEF;
    b0 = bc[0]; r0 = rc[0];
    do_load(0, 16'h009F);
    wait_idle(0, 60);
    chk("t1_busy_cycles", bc[0] - b0, 36);
    chk("t1_sck_pulses", rc[0] - r0, 8);
    chk("t1_sdo_stream", cap[0], 8'h9F);
    chk("t1_out", out0, 16'h00EF);
    chk("t1_csx_held", csx0, 0);

    // deselect, then a redundant deselect
    b0 = bc[0];
    do_load(0, 16'h0100);
    @(negedge clk); #1;
    chk("t2_csx_release", csx0, 1);
    do_load(0, 16'h0100);
    repeat (4) @(negedge clk);
    #1;
    chk("t2_no_busy", bc[0] - b0, 0);
    chk("t2_out_kept", out0, 16'h00EF);

    // mode 3, DIV=1, echo slave
    s_resp[1] = 8'hA5;
    b0 = bc[1]; r0 = rc[1];
    do_load(1, 16'h00A5);
    wait_idle(1, 40);
    chk("t3_busy_cycles", bc[1] - b0, 18);
    chk("t3_sck_pulses", rc[1] - r0, 8);
    chk("t3_sdo_stream", cap[1], 8'hA5);
    chk("t3_out", out1, 16'h00A5);
    chk("t3_sck_idle", sck1, 1);

    // load during busy is ignored
    s_resp[0] = 8'h81;
    b0 = bc[0]; r0 = rc[0];
    do_load(0, 16'h00C6);
    repeat (6) @(posedge clk);
    do_load(0, 16'h0055);
    wait_idle(0, 60);
    chk("t4_busy_cycles", bc[0] - b0, 36);
    chk("t4_sdo_stream", cap[0], 8'hC6);
    chk("t4_out", out0, 16'h0081);

    // reset at bit 4 of a transfer
    s_resp[0] = 8'h66;
    r0 = rc[0];
    do_load(0, 16'h00F0);
    k = 0;
    while (rc[0] - r0 < 4 && k < 60) begin
      @(negedge clk); #1;
      k++;
    end
    chk("t5_reached_bit4", rc[0] - r0, 4);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_csx", csx0, 1);
    chk("t5_rst_sck", sck0, 0);
    chk("t5_rst_out", out0, 16'h0000);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    s_resp[0] = 8'h5A;
    do_load(0, 16'h00C3);
    wait_idle(0, 60);
    chk("t5_after_out", out0, 16'h005A);
    chk("t5_after_sdo", cap[0], 8'hC3);

`ifdef SPI_LOOPBACK_EN
    lb = 1'b1;
    do_load(0, 16'h003C);
    wait_idle(0, 60);
    chk("t6_loopback_out", out0, 16'h003C);
    lb = 1'b0;
`endif

    repeat (3) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
